mem_responder: RTL
==================

# mem_responder

Byte-wide memory and I/O responder at the far end of the CPU memory bus. It serves single-byte reads and writes issued by the memory controller, one byte per cycle. RAM accesses go to an internal byte array. Accesses to the I/O window go to a UART TX FIFO and an RX FIFO. It drives `io_buffer_full` back to the controller so that UART stores stall instead of being dropped.

## Interface
Parameters:
- `ADDR_WIDTH`, 17: RAM index width; RAM holds 2^ADDR_WIDTH bytes.
- `TX_DEPTH`, 16: TX FIFO entries; power of two, ≥ 4.
- `RX_DEPTH`, 16: RX FIFO entries; power of two, ≥ 2.

Ports:
- `clk_in`, in, 1: the single clock.
- `rst_in`, in, 1: reset, synchronous, active-high.
- `cpu_a`, in, 32: byte address. Only bits [17:0] are decoded.
- `cpu_wr`, in, 1: 1 = write, 0 = read.
- `cpu_dout`, in, 8: write data from the controller.
- `cpu_din`, out, 8: read data to the controller (registered).
- `io_buffer_full`, out, 1: TX FIFO near full (registered).
- `tx_data`, out, 8: head byte of the TX FIFO.
- `tx_valid`, out, 1: TX FIFO non-empty.
- `tx_ready`, in, 1: UART accepts `tx_data` this cycle.
- `rx_data`, in, 8: received byte.
- `rx_valid`, in, 1: push `rx_data` this cycle.
- `sim_done`, out, 1: sticky; set by a write to the halt address.
- `tx_overflow`, out, 1: sticky; set by a write to a truly full TX FIFO.

## Operation
Address decode:
- The access is I/O when `cpu_a[17:16]==2'b11`.
- Otherwise it is RAM, at index `cpu_a[ADDR_WIDTH-1:0]`.

RAM:
- Write: `mem[idx] <= cpu_dout`.
- Read: `cpu_din <= mem[idx]`.
- RAM contents are not affected by reset.

I/O write:
- `0x30000`: push `cpu_dout` into the TX FIFO. If the FIFO is completely full, drop the byte and set `tx_overflow`.
- `0x30004`: set `sim_done`.
- Any other I/O address: ignored.

I/O read:
- `0x30000`: `cpu_din <=` RX head and pop it. If the RX FIFO is empty, return `8'h00` and do not pop.
- `0x30004`: `cpu_din <= {6'b0, rx_nonempty, tx_full}`.
- Any other I/O address: `cpu_din <= 8'h00`.

`io_buffer_full`:
- Registered; equals `tx_count >= TX_DEPTH-2` as of the previous edge.
- The two-slot reserve covers the cycle between the controller sampling the flag and its write arriving here.

TX drain:
- A pop happens when `tx_valid & tx_ready`.
- A push and a pop in the same cycle leave the count unchanged. This is legal even when the FIFO is full, because the pop frees a slot.

RX fill:
- A push happens when `rx_valid`.
- If the RX FIFO is full, the byte is dropped silently.
- A simultaneous push and pop are both applied.

## Timing
- The bus has no handshake. Every cycle with `cpu_wr=1` is a write.
- An idle bus (`cpu_a=0`, `cpu_wr=0`) reads RAM[0]. This read is harmless, since RAM reads have no side effects.
- Read latency is 1: `cpu_a` presented in cycle t gives `cpu_din` valid in cycle t+1. Back-to-back reads of a, a+1, … return one byte per cycle.
- A write becomes visible to a read of the same address issued in the next cycle.
- Read-side effects (RX pop) happen at the edge that samples the address, exactly once per read cycle.
- Reset values:
  - `cpu_din=0`, `io_buffer_full=0`, `tx_valid=0`, `tx_data=0`, `sim_done=0`, `tx_overflow=0`.
  - Both FIFOs empty.
- Reset asserted mid-burst: the FIFOs are flushed at that edge and any bus access sampled in that cycle is ignored.

## Structure
- Shared package `mem_map_pkg`:
  - `IO_UART_ADDR = 18'h30000`
  - `IO_HALT_ADDR = 18'h30004`
  - the I/O region predicate on bits [17:16]
- One sub-module, `byte_fifo`:
  - Parameters: `DEPTH`.
  - Ports: push/pop/din/dout/count/full/empty.
  - Synchronous reset.
  - Instantiated twice, for TX and RX.
- The top level contains the decode, the RAM array, the read mux register, and the sticky flags.

## Test plan
- RAM round trip: write `0x12,0x34,0x56,0x78` to `0x00100..0x00103` on consecutive cycles, then read the four addresses back-to-back → `cpu_din` equals `0x12,0x34,0x56,0x78` in cycles t+1..t+4.
- TX backpressure: hold `tx_ready=0` and write `0x41` to `0x30000` 14 times → `io_buffer_full` rises one cycle after the 14th push. With 2 more writes, `tx_overflow` stays 0. A 17th write sets `tx_overflow`. Then raise `tx_ready` → `tx_data` is `0x41` for 16 cycles and `io_buffer_full` drops once `count<14`.
- RX read: push `0x5A`, `0xA5` via `rx_valid`. Read `0x30004` → `8'h02`. Read `0x30000` twice → `0x5A`, then `0xA5`. A third read → `0x00`, and the status read returns `0x00`.
- Simultaneous events: TX full with `tx_ready=1` and a write in the same cycle → count stays 16 and no overflow. RX full with `rx_valid` and a read in the same cycle → the head is returned, the new byte is stored, and the count is unchanged.
- Halt and reset: write to `0x30004` → `sim_done=1` next cycle. Assert `rst_in` during a TX drain → all outputs return to their reset values at that edge, and RAM[0x100] still reads `0x12`.

Source files
------------

// File: rtl/mem_map_pkg.sv
// Shared memory map for the CPU far-end bus: I/O window addresses and
// the access classifier used by the responder decode.
package mem_map_pkg;

  localparam logic [17:0] IO_UART_ADDR = 18'h30000;
  localparam logic [17:0] IO_HALT_ADDR = 18'h30004;

  typedef enum logic [1:0] {
    ACC_RAM,
    ACC_UART,
    ACC_HALT,
    ACC_IO_NONE
  } acc_kind_t;

  function automatic logic is_io(input logic [17:0] a);
    return a[17:16] == 2'b11;
  endfunction

  function automatic acc_kind_t decode(input logic [17:0] a);
    if (!is_io(a))              return ACC_RAM;
    else if (a == IO_UART_ADDR) return ACC_UART;
    else if (a == IO_HALT_ADDR) return ACC_HALT;
    else                        return ACC_IO_NONE;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Byte bus between the memory controller (master) and the responder (slave).
interface mem_responder_if;
  import mem_map_pkg::*;

  logic [31:0] cpu_a;
  logic        cpu_wr;
  logic [7:0]  cpu_dout;
  logic [7:0]  cpu_din;
  logic        io_buffer_full;

  modport master (
    output cpu_a, cpu_wr, cpu_dout,
    input  cpu_din, io_buffer_full
  );

  modport slave (
    input  cpu_a, cpu_wr, cpu_dout,
    output cpu_din, io_buffer_full
  );
endinterface

// File: rtl/byte_fifo.sv
// Byte FIFO with synchronous reset. A push while full is accepted only when
// a pop happens in the same cycle; dout reads 0 while empty.
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? 8'h00 : mem[rd_ptr];

  always_ff @(posedge clk_in) begin
    if (do_push && !rst_in) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/mem_responder.sv
// Far-end byte responder: RAM array plus UART TX/RX FIFOs in the I/O window,
// with a registered read mux and sticky halt/overflow flags.
module mem_responder
  import mem_map_pkg::*;
#(
  parameter int ADDR_WIDTH = 17,
  parameter int TX_DEPTH   = 16,
  parameter int RX_DEPTH   = 16
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  mem_responder_if.slave        bus,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  sim_done,
  output logic                  tx_overflow
);
  localparam int TCW = $clog2(TX_DEPTH) + 1;
  localparam int RCW = $clog2(RX_DEPTH) + 1;
  // Two-slot reserve absorbs the write already in flight when the flag is seen.
  localparam logic [TCW-1:0] TX_RESERVE = TCW'(TX_DEPTH - 2);

  logic [7:0]            ram [2**ADDR_WIDTH];
  logic [17:0]           a18;
  logic [ADDR_WIDTH-1:0] idx;
  acc_kind_t             kind;
  logic                  unused_addr_hi;

  logic                  tx_push, tx_pop, tx_full, tx_empty;
  logic [TCW-1:0]        tx_count;
  logic                  rx_pop, rx_full, rx_empty;
  logic [7:0]            rx_head;
  logic [RCW-1:0]        unused_rx_count;
  logic                  unused_rx_full;

  assign a18            = bus.cpu_a[17:0];
  assign idx            = bus.cpu_a[ADDR_WIDTH-1:0];
  assign kind           = decode(a18);
  assign unused_addr_hi = ^bus.cpu_a[31:18];
  assign unused_rx_full = rx_full;

  assign tx_valid = !tx_empty;
  assign tx_pop   = tx_valid && tx_ready;
  assign tx_push  = bus.cpu_wr && (kind == ACC_UART);
  assign rx_pop   = !bus.cpu_wr && (kind == ACC_UART) && !rx_empty;

  byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .push   (tx_push),
    .pop    (tx_pop),
    .din    (bus.cpu_dout),
    .dout   (tx_data),
    .count  (tx_count),
    .full   (tx_full),
    .empty  (tx_empty)
  );

  byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .push   (rx_valid),
    .pop    (rx_pop),
    .din    (rx_data),
    .dout   (rx_head),
    .count  (unused_rx_count),
    .full   (rx_full),
    .empty  (rx_empty)
  );

  // RAM survives reset; only the write is suppressed while reset is held.
  always_ff @(posedge clk_in) begin
    if (!rst_in && bus.cpu_wr && (kind == ACC_RAM)) ram[idx] <= bus.cpu_dout;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      bus.cpu_din        <= 8'h00;
      bus.io_buffer_full <= 1'b0;
      sim_done           <= 1'b0;
      tx_overflow        <= 1'b0;
    end else begin
      bus.io_buffer_full <= (tx_count >= TX_RESERVE);
      if (bus.cpu_wr) begin
        if (kind == ACC_HALT) sim_done <= 1'b1;
        if (tx_push && tx_full && !tx_pop) tx_overflow <= 1'b1;
      end else begin
        case (kind)
          ACC_RAM:  bus.cpu_din <= ram[idx];
          ACC_UART: bus.cpu_din <= rx_head;
          ACC_HALT: bus.cpu_din <= {6'b0, !rx_empty, tx_full};
          default:  bus.cpu_din <= 8'h00;
        endcase
      end
    end
  end
endmodule
